// File: rtl/pipelined_decoder_if.sv
// Fetch/execute handshake bundle for pipelined_decoder.
// Optional illegal_op signal exists only when DEC_ILLEGAL_TRAP_EN is defined.
interface pipelined_decoder_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_W    = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                out_valid;
  logic                out_ready;
  logic [ALU_W-1:0]    alu_func;
  logic                pc_rel_branch;
  logic                reg_write;
  logic                immediate;
  logic                read_in;
  logic                write_out;
  logic                busy;
`ifdef DEC_ILLEGAL_TRAP_EN
  logic                illegal_op;
`endif

  // Environment side: fetch drives opcodes, execute drives out_ready.
  modport master (
    output in_valid, opcode, out_ready,
    input  in_ready, out_valid, alu_func, pc_rel_branch, reg_write,
           immediate, read_in, write_out, busy
`ifdef DEC_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );

  // Decoder side.
  modport slave (
    input  in_valid, opcode, out_ready,
    output in_ready, out_valid, alu_func, pc_rel_branch, reg_write,
           immediate, read_in, write_out, busy
`ifdef DEC_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );
endinterface

// File: rtl/pipelined_decoder.sv
// pipelined_decoder: registered opcode decoder between fetch and execute.
// One cycle of latency, valid/ready on both sides, stalls fetch while a
// multi-cycle multiply occupies execute, squashes BRANCH_KILL instructions
// after each issued JMP.
// Optional feature macro: DEC_ILLEGAL_TRAP_EN (adds illegal_op output).
module pipelined_decoder #(
  parameter int OPCODE_W    = 6,
  parameter int ALU_W       = 3,
  parameter int MLT_CYCLES  = 3,
  parameter int BRANCH_KILL = 1
) (
  input logic              clk,
  input logic              reset,
  pipelined_decoder_if.slave bus
);

  // Opcode encodings
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'h01);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'h03);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_MLT  = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_MLTI = OPCODE_W'(6'h06);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6'h07);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(6'h09);

  // ALU function encodings
  localparam logic [ALU_W-1:0] RADD = ALU_W'(3'd1);
  localparam logic [ALU_W-1:0] RSUB = ALU_W'(3'd2);
  localparam logic [ALU_W-1:0] RMLT = ALU_W'(3'd3);

  localparam logic [3:0] MLT_LOAD   = 4'(MLT_CYCLES - 1);
  localparam logic [3:0] KILL_LOAD  = 4'(BRANCH_KILL);
  // Remaining squashes when the first wrong-path opcode arrives in the
  // same cycle the JMP issues.
  localparam logic [3:0] KILL_AFTER = 4'(BRANCH_KILL - 1);

  typedef enum logic [1:0] {RUN, MULT_WAIT, KILL} state_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             pc_rel;
    logic             reg_write;
    logic             imm;
    logic             read_in;
    logic             write_out;
  } bundle_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       vld_q, vld_d;
  logic       load;
  bundle_t    bundle_q, dec;
  logic       out_valid, accept, issue, mlt_issue, jmp_issue;

`ifdef DEC_ILLEGAL_TRAP_EN
  logic       dec_illegal, illegal_q;
`endif

  // The held bundle is hidden from execute while a multiply is running.
  assign out_valid    = vld_q && (state_q == RUN);
  assign bus.in_ready = ((state_q == RUN) || (state_q == KILL)) && (!vld_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign issue        = out_valid && bus.out_ready;
  assign mlt_issue    = issue && (bundle_q.alu == RMLT) && (MLT_CYCLES > 1);
  assign jmp_issue    = issue && bundle_q.pc_rel && (BRANCH_KILL > 0);

  // Opcode to control bundle; undefined opcodes fall through as all-zero.
  always_comb begin
    dec = '0;
`ifdef DEC_ILLEGAL_TRAP_EN
    dec_illegal = 1'b0;
`endif
    case (bus.opcode)
      OP_NOP:  ;
      OP_ADD:  begin dec.alu = RADD; dec.reg_write = 1'b1; end
      OP_SUB:  begin dec.alu = RSUB; dec.reg_write = 1'b1; end
      OP_ADDI: begin dec.alu = RADD; dec.imm = 1'b1; dec.reg_write = 1'b1; end
      OP_SUBI: begin dec.alu = RSUB; dec.imm = 1'b1; dec.reg_write = 1'b1; end
      OP_MLT:  begin dec.alu = RMLT; dec.reg_write = 1'b1; end
      OP_MLTI: begin dec.alu = RMLT; dec.imm = 1'b1; dec.reg_write = 1'b1; end
      OP_JMP:  dec.pc_rel = 1'b1;
      OP_LD:   begin dec.read_in = 1'b1; dec.reg_write = 1'b1; end
      OP_ST:   dec.write_out = 1'b1;
`ifdef DEC_ILLEGAL_TRAP_EN
      default: dec_illegal = 1'b1;
`else
      default: ;
`endif
    endcase
  end

  // Next-state, counter and output-valid control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    load    = 1'b0;
    case (state_q)
      RUN: begin
        if (mlt_issue) begin
          state_d = MULT_WAIT;
          cnt_d   = MLT_LOAD;
        end
        if (jmp_issue) begin
          // Anything accepted alongside the JMP is already wrong-path.
          vld_d = 1'b0;
          if (!accept) begin
            state_d = KILL;
            cnt_d   = KILL_LOAD;
          end else if (BRANCH_KILL > 1) begin
            state_d = KILL;
            cnt_d   = KILL_AFTER;
          end
        end else if (accept) begin
          load  = 1'b1;
          vld_d = 1'b1;
        end else if (issue) begin
          vld_d = 1'b0;
        end
      end
      MULT_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      KILL: begin
        if (accept) begin
          if (cnt_q == 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State, counter and valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // Output bundle register; holds its value until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q <= '0;
    end else if (load) begin
      bundle_q <= dec;
    end
  end

`ifdef DEC_ILLEGAL_TRAP_EN
  // Illegal flag travels with the bundle it was decoded from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (load) begin
      illegal_q <= dec_illegal;
    end
  end
  assign bus.illegal_op = illegal_q;
`endif

  assign bus.out_valid     = out_valid;
  assign bus.alu_func      = bundle_q.alu;
  assign bus.pc_rel_branch = bundle_q.pc_rel;
  assign bus.reg_write     = bundle_q.reg_write;
  assign bus.immediate     = bundle_q.imm;
  assign bus.read_in       = bundle_q.read_in;
  assign bus.write_out     = bundle_q.write_out;
  assign bus.busy          = (state_q != RUN);

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: directed scenarios plus a randomized stream
// checked against an in-order reference model of the emitted bundles.
module tb_pipelined_decoder;
  localparam int MLT_CYCLES  = 3;
  localparam int BRANCH_KILL = 1;

  localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, ADDI = 6'h02, SUB = 6'h03,
                         SUBI = 6'h04, MLT = 6'h05, MLTI = 6'h06, JMP = 6'h07,
                         LD = 6'h08, ST = 6'h09;
  localparam logic [2:0] RADD = 3'd1, RSUB = 3'd2, RMLT = 3'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_decoder_if #(.OPCODE_W(6), .ALU_W(3)) bus ();

  pipelined_decoder #(
    .OPCODE_W(6), .ALU_W(3), .MLT_CYCLES(MLT_CYCLES), .BRANCH_KILL(BRANCH_KILL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Bundle view: {alu, pc_rel, reg_write, imm, read_in, write_out, illegal}
  function automatic logic [8:0] get_bundle();
    logic ill;
`ifdef DEC_ILLEGAL_TRAP_EN
    ill = bus.illegal_op;
`else
    ill = 1'b0;
`endif
    return {bus.alu_func, bus.pc_rel_branch, bus.reg_write, bus.immediate,
            bus.read_in, bus.write_out, ill};
  endfunction

  // Reference decode table.
  function automatic logic [8:0] exp_bundle(input logic [5:0] op);
    logic [2:0] alu = 3'd0;
    logic j = 0, w = 0, i = 0, rd = 0, wr = 0, il = 0;
    case (op)
      NOP:  ;
      ADD:  begin alu = RADD; w = 1; end
      SUB:  begin alu = RSUB; w = 1; end
      ADDI: begin alu = RADD; i = 1; w = 1; end
      SUBI: begin alu = RSUB; i = 1; w = 1; end
      MLT:  begin alu = RMLT; w = 1; end
      MLTI: begin alu = RMLT; i = 1; w = 1; end
      JMP:  j = 1;
      LD:   begin rd = 1; w = 1; end
      ST:   wr = 1;
`ifdef DEC_ILLEGAL_TRAP_EN
      default: il = 1;
`else
      default: ;
`endif
    endcase
    return {alu, j, w, i, rd, wr, il};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.opcode    = op;
    bus.out_ready = r;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.opcode = NOP; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(1'b0, NOP, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (get_bundle() !== 9'h0) begin errors++; $display("FAIL reset_bundle: got %h expected 000", get_bundle()); end
  endtask

  task automatic test_stream();
    logic [5:0] seq [6];
    seq = '{ADD, SUB, ADDI, SUBI, LD, ST};
    apply_reset();
    for (int k = 0; k <= 7; k++) begin
      if (k < 6) drive(1'b1, seq[k], 1'b1);
      else       drive(1'b0, NOP, 1'b1);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, bus.in_ready); end
      if (k >= 1 && k <= 6) begin
        checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(seq[k-1]))
          begin errors++; $display("FAIL stream_bundle[%0d]: got v=%b %h expected v=1 %h", k, bus.out_valid, get_bundle(), exp_bundle(seq[k-1])); end
      end
      if (k == 7) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_mult();
    apply_reset();
    drive(1'b1, MLT, 1'b1);
    drive(1'b1, ADD, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(MLT))
      begin errors++; $display("FAIL mult_issue: got v=%b %h expected v=1 %h", bus.out_valid, get_bundle(), exp_bundle(MLT)); end
    for (int k = 1; k < MLT_CYCLES; k++) begin
      drive(1'b0, NOP, 1'b1);
      checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
        begin errors++; $display("FAIL mult_stall[T+%0d]: got busy=%b rdy=%b v=%b expected 1 0 0", k, bus.busy, bus.in_ready, bus.out_valid); end
    end
    drive(1'b0, NOP, 1'b1);
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(ADD))
      begin errors++; $display("FAIL mult_resume: got busy=%b v=%b %h expected 0 1 %h", bus.busy, bus.out_valid, get_bundle(), exp_bundle(ADD)); end
  endtask

  task automatic test_jump();
    apply_reset();
    drive(1'b1, JMP, 1'b1);
    drive(1'b1, SUB, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.pc_rel_branch !== 1'b1 || get_bundle() !== exp_bundle(JMP))
      begin errors++; $display("FAIL jump_bundle: got v=%b %h expected v=1 %h", bus.out_valid, get_bundle(), exp_bundle(JMP)); end
    drive(1'b1, ADD, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL jump_squash: got v=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready); end
    drive(1'b0, NOP, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(ADD))
      begin errors++; $display("FAIL jump_next: got v=%b %h expected v=1 %h", bus.out_valid, get_bundle(), exp_bundle(ADD)); end
    drive(1'b0, NOP, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL jump_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(1'b1, LD, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ADD, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.read_in !== 1'b1 || bus.reg_write !== 1'b1 || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d]: got v=%b rd=%b w=%b rdy=%b expected 1 1 1 0", k, bus.out_valid, bus.read_in, bus.reg_write, bus.in_ready); end
    end
    drive(1'b1, ADD, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(LD) || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL stall_release: got v=%b %h rdy=%b expected 1 %h 1", bus.out_valid, get_bundle(), bus.in_ready, exp_bundle(LD)); end
    drive(1'b0, NOP, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(ADD))
      begin errors++; $display("FAIL stall_next: got v=%b %h expected v=1 %h", bus.out_valid, get_bundle(), exp_bundle(ADD)); end
  endtask

  task automatic test_reset_mid_mult();
    apply_reset();
    drive(1'b1, MLT, 1'b1);
    drive(1'b0, NOP, 1'b1);   // MLT issues
    drive(1'b0, NOP, 1'b1);   // MULT_WAIT, cnt=2
    @(negedge clk);           // MULT_WAIT, cnt=1
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || get_bundle() !== 9'h0)
      begin errors++; $display("FAIL reset_mid_async: got busy=%b v=%b %h expected 0 0 000", bus.busy, bus.out_valid, get_bundle()); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || get_bundle() !== 9'h0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_mid_after: got busy=%b v=%b %h rdy=%b expected 0 0 000 1", bus.busy, bus.out_valid, get_bundle(), bus.in_ready); end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(1'b1, 6'h3F, 1'b1);
    drive(1'b1, ADD, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(6'h3F))
      begin errors++; $display("FAIL illegal_bundle: got v=%b %h expected v=1 %h", bus.out_valid, get_bundle(), exp_bundle(6'h3F)); end
`ifdef DEC_ILLEGAL_TRAP_EN
    checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", bus.illegal_op); end
`endif
    drive(1'b0, NOP, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== exp_bundle(ADD))
      begin errors++; $display("FAIL illegal_clear: got v=%b %h expected v=1 %h", bus.out_valid, get_bundle(), exp_bundle(ADD)); end
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    logic [8:0] exp_q [$];
    logic [8:0] held, e;
    logic       held_valid = 1'b0;
    logic       v, r;
    logic [5:0] op;
    int         kill_rem = 0;
    int         mult_stall = 0;
    ops = '{NOP, ADD, ADDI, SUB, SUBI, MLT, MLTI, JMP, LD, ST, 6'h3F, 6'h2A};
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c < 1980) begin
        v  = ($urandom_range(0, 9) < 7);
        op = ops[$urandom_range(0, 11)];
        r  = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b0; op = NOP; r = 1'b1;
      end
      drive(v, op, r);
      if (mult_stall > 0) begin
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
          begin errors++; $display("FAIL rand_mult_stall[%0d]: got v=%b rdy=%b busy=%b expected 0 0 1", c, bus.out_valid, bus.in_ready, bus.busy); end
        mult_stall--;
      end else begin
        checks++; if (bus.in_ready !== (!bus.out_valid || r))
          begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, bus.in_ready, (!bus.out_valid || r)); end
      end
      if (held_valid) begin
        checks++; if (bus.out_valid !== 1'b1 || get_bundle() !== held)
          begin errors++; $display("FAIL rand_hold[%0d]: got v=%b %h expected v=1 %h", c, bus.out_valid, get_bundle(), held); end
      end
      held_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (r) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rand_extra[%0d]: got %h expected no bundle", c, get_bundle());
          end else begin
            e = exp_q.pop_front();
            if (get_bundle() !== e) begin errors++; $display("FAIL rand_bundle[%0d]: got %h expected %h", c, get_bundle(), e); end
            if (e[8:6] == RMLT) mult_stall = MLT_CYCLES - 1;
          end
        end else begin
          held_valid = 1'b1;
          held = get_bundle();
        end
      end
      // In-order model: each JMP hides the next BRANCH_KILL accepted opcodes.
      if (v && bus.in_ready === 1'b1) begin
        if (kill_rem > 0) kill_rem--;
        else begin
          exp_q.push_back(exp_bundle(op));
          if (op == JMP) kill_rem = BRANCH_KILL;
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.opcode = NOP; bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_mult();
    test_jump();
    test_stall();
    test_reset_mid_mult();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
